axis_to_stream_rx: RTL and testbench
====================================

Name: axis_to_stream_rx

Overview:
- Receive-side bridge from a standard AXI4-Stream master (Vitis kernel port: tvalid/tready/tdata/tkeep/tlast/tuser) to the internal if_axi_stream source (val/rdy/sop/eop/mod/err/ctl/dat).
- Regenerates sop and converts tkeep to mod.
- Checks keep legality.
- Registers both directions with a 2-entry skid buffer, giving full throughput and no combinational path from o_str.rdy to o_axis_tready.
- Sits at the kernel ingress, ahead of the ZKP datapath.

Parameters:
- DAT_BYTS, 64, bytes per beat; tdata width is DAT_BYTS*8.
- CTL_BITS, 8, width of tuser, mapped to ctl.
- MOD_BITS, $clog2(DAT_BYTS) (1 when DAT_BYTS==1), width of mod.
- CNT_BITS, 32, width of the packet counter.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_axis_tvalid  in  1  AXI4-Stream beat valid.
- o_axis_tready  out  1  AXI4-Stream ready.
- i_axis_tdata  in  DAT_BYTS*8  beat data; byte 0 is in bits [7:0].
- i_axis_tkeep  in  DAT_BYTS  byte enables.
- i_axis_tlast  in  1  last beat of packet.
- i_axis_tuser  in  CTL_BITS  sideband, sampled on every beat.
- o_str  if_axi_stream.source  -  internal stream; rdy is the only input on this port.
- o_pkt_cnt  out  CNT_BITS  packets emitted (eop handshakes), wraps.
- o_err_cnt  out  16  beats emitted with err=1, saturates at 16'hFFFF.

Behaviour:
- Reset (i_rst=1 at a clock edge) clears:
  - o_axis_tready=0, o_str.val/sop/eop/err=0, mod/ctl/dat=0;
  - skid buffer, in_pkt flag, o_pkt_cnt=0, o_err_cnt=0.
  - o_axis_tready rises on the first cycle after reset deasserts.
  - Reset mid-packet discards all buffered beats; the next accepted beat is treated as sop.
- Handshakes:
  - Input accepted when i_axis_tvalid && o_axis_tready.
  - Output consumed when o_str.val && o_str.rdy.
  - o_str fields are held stable while val && !rdy.
- Buffering: output register plus one skid register.
  - o_axis_tready = !skid_full, registered.
  - If an accepted beat finds the output register occupied and not draining, it goes to the skid register.
  - When the output drains, the skid register moves to output in the same cycle.
  - Latency: accepted beat appears on o_str one cycle later.
  - Throughput: 1 beat/cycle sustained when rdy=1.
  - Never drops or reorders a beat.
- sop generation: in_pkt flag.
  - sop = !in_pkt at the time the beat is accepted.
  - in_pkt is set on an accepted non-last beat and cleared on an accepted last beat.
  - A single-beat packet has sop=eop=1.
- eop = tlast.
- mod:
  - eop beat: mod = popcount(tkeep) truncated to MOD_BITS, so a full last beat gives mod=0, meaning "all bytes".
  - Non-eop beat: mod=0.
- dat = tdata unmodified, including bytes where keep is 0. ctl = tuser.
- Null beat (tkeep==0 && !tlast): accepted and dropped; no output beat, in_pkt unchanged.
- err=1 on the output beat when any of the following holds:
  - (a) a non-last beat has tkeep != all-ones;
  - (b) a last beat has a non-contiguous tkeep (not of the form 0..01..1);
  - (c) a last beat has tkeep==0 (it is still emitted with mod=0).
- err is per-beat and does not abort the packet.
- Counters update on the output handshake:
  - o_pkt_cnt increments on eop.
  - o_err_cnt increments on err.
  - Both are updated in the same cycle if simultaneous.

Decomposition:
- common_pkg gets:
  - function keep_to_mod(keep) returning popcount truncated to MOD_BITS;
  - function keep_is_contig(keep);
  - localparam ERR_CNT_BITS=16.
- Sub-module stream_skid_buf: generic 2-entry register slice on a packed {dat,ctl,mod,sop,eop,err} word with registered upstream ready.
  - It is reused later by the transmit-side stream_to_axis_tx.
- The top level holds the sop/in_pkt logic, keep checks and counters.

Test Plan:
- Single 200-byte packet, DAT_BYTS=64: keeps all-ones x3 then 64'h00FF, rdy=1 -> 4 beats; sop on beat 0; eop on beat 3 with mod=8; err=0 throughout; o_pkt_cnt=1; tready stays 1.
- Back-to-back packets of 64B and 128B, tvalid=1 continuously -> 3 beats on consecutive cycles; sop on beats 0 and 1; eop on beats 0 and 2 with mod=0; o_pkt_cnt=2.
- Random rdy at 50% backpressure over 1000 random packets -> scoreboard byte-exact match; tready low only while skid is full; no beat lost or duplicated.
- Last-beat keep 64'h0F0F -> err=1, mod=8, o_err_cnt=1. Non-last keep 64'h7FFF... -> err=1.
- Null beat (keep=0, last=0) mid-packet -> dropped; next beat has sop=0; beat count unchanged.
- Assert i_rst after beat 2 of a 4-beat packet while output is stalled -> all outputs are 0 at the next edge; the first post-reset beat has sop=1; counters are 0.

Source files
------------

// File: rtl/axis_to_stream_rx_pkg.sv
// Shared helpers for the AXI4-Stream ingress bridge: keep-to-mod conversion
// and keep contiguity check, sized for up to MAX_BYTS byte lanes.
package axis_to_stream_rx_pkg;

  localparam int ERR_CNT_BITS = 16;
  localparam int MAX_BYTS     = 128;

  // Popcount of the byte enables; callers truncate to their MOD_BITS.
  function automatic logic [7:0] keep_to_mod(input logic [MAX_BYTS-1:0] keep);
    logic [7:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_BYTS; i++) begin
      cnt = cnt + 8'(keep[i]);
    end
    return cnt;
  endfunction

  // True when keep is of the form 0..01..1 (all-zero also qualifies).
  function automatic logic keep_is_contig(input logic [MAX_BYTS-1:0] keep);
    return (keep & (keep + MAX_BYTS'(1))) == '0;
  endfunction

endpackage

// File: rtl/axis_to_stream_rx_if.sv
// Internal valid/ready stream bus with packet framing, modulo and sideband.
interface if_axi_stream #(
  parameter int DAT_BYTS = 64,
  parameter int CTL_BITS = 8,
  parameter int MOD_BITS = (DAT_BYTS == 1) ? 1 : $clog2(DAT_BYTS)
) ();

  logic                  val;
  logic                  rdy;
  logic                  sop;
  logic                  eop;
  logic                  err;
  logic [MOD_BITS-1:0]   mod;
  logic [CTL_BITS-1:0]   ctl;
  logic [DAT_BYTS*8-1:0] dat;

  modport source (output val, sop, eop, err, mod, ctl, dat, input rdy);
  modport sink   (input val, sop, eop, err, mod, ctl, dat, output rdy);
  modport master (output val, sop, eop, err, mod, ctl, dat, input rdy);
  modport slave  (input val, sop, eop, err, mod, ctl, dat, output rdy);

endinterface

// File: rtl/axis_to_stream_rx_skid_buf.sv
// Generic 2-entry register slice (output register + skid register) with a
// registered upstream ready, so no combinational path from i_rdy to o_rdy.
module stream_skid_buf #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_vld,
  output logic         o_rdy,
  input  logic [W-1:0] i_dat,
  output logic         o_vld,
  input  logic         i_rdy,
  output logic [W-1:0] o_dat
);

  logic         out_vld_p1;
  logic         skid_vld_p1;
  logic         rdy_p1;
  logic [W-1:0] out_dat_p1;
  logic [W-1:0] skid_dat_p1;
  logic         acc;
  logic         out_free;
  logic         skid_vld_nxt;

  assign acc      = i_vld && rdy_p1;
  assign out_free = !out_vld_p1 || i_rdy;
  // A full skid register always empties into a free output register first.
  assign skid_vld_nxt = out_free ? 1'b0 : (skid_vld_p1 || acc);

  // p0 -> p1: output and skid registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_vld_p1  <= 1'b0;
      skid_vld_p1 <= 1'b0;
      rdy_p1      <= 1'b0;
      out_dat_p1  <= '0;
      skid_dat_p1 <= '0;
    end else begin
      skid_vld_p1 <= skid_vld_nxt;
      rdy_p1      <= !skid_vld_nxt;
      if (out_free) begin
        if (skid_vld_p1) begin
          out_vld_p1 <= 1'b1;
          out_dat_p1 <= skid_dat_p1;
        end else begin
          out_vld_p1 <= acc;
          if (acc) out_dat_p1 <= i_dat;
        end
      end else if (acc) begin
        skid_dat_p1 <= i_dat;
      end
    end
  end

  assign o_rdy = rdy_p1;
  assign o_vld = out_vld_p1;
  assign o_dat = out_dat_p1;

endmodule

// File: rtl/axis_to_stream_rx.sv
// AXI4-Stream to internal stream ingress bridge: regenerates sop, converts
// tkeep to mod, flags illegal keeps, and counts packets and error beats.
module axis_to_stream_rx
  import axis_to_stream_rx_pkg::*;
#(
  parameter int DAT_BYTS = 64,
  parameter int CTL_BITS = 8,
  parameter int MOD_BITS = (DAT_BYTS == 1) ? 1 : $clog2(DAT_BYTS),
  parameter int CNT_BITS = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_axis_tvalid,
  output logic                    o_axis_tready,
  input  logic [DAT_BYTS*8-1:0]   i_axis_tdata,
  input  logic [DAT_BYTS-1:0]     i_axis_tkeep,
  input  logic                    i_axis_tlast,
  input  logic [CTL_BITS-1:0]     i_axis_tuser,
  if_axi_stream.source            o_str,
  output logic [CNT_BITS-1:0]     o_pkt_cnt,
  output logic [ERR_CNT_BITS-1:0] o_err_cnt
);

  localparam int W = DAT_BYTS*8 + CTL_BITS + MOD_BITS + 3;

  logic [MAX_BYTS-1:0] keep_ext;
  logic                acc;
  logic                is_null;
  logic                in_pkt;
  logic                sop_p0;
  logic                err_p0;
  logic [MOD_BITS-1:0] mod_p0;
  logic [W-1:0]        word_p0;
  logic [W-1:0]        word_p1;
  logic                hs;

  assign keep_ext = MAX_BYTS'(i_axis_tkeep);
  assign acc      = i_axis_tvalid && o_axis_tready;
  assign is_null  = (i_axis_tkeep == '0) && !i_axis_tlast;
  assign sop_p0   = !in_pkt;
  assign mod_p0   = i_axis_tlast ? MOD_BITS'(keep_to_mod(keep_ext)) : '0;
  assign err_p0   = i_axis_tlast ? (!keep_is_contig(keep_ext) || (i_axis_tkeep == '0))
                                 : (i_axis_tkeep != '1);
  assign word_p0  = {i_axis_tdata, i_axis_tuser, mod_p0, sop_p0, i_axis_tlast, err_p0};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      in_pkt <= 1'b0;
    end else if (acc && !is_null) begin
      in_pkt <= !i_axis_tlast;
    end
  end

  // p0 -> p1: skid buffer; null beats are consumed upstream but never pushed
  stream_skid_buf #(.W(W)) u_skid (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_vld (i_axis_tvalid && !is_null),
    .o_rdy (o_axis_tready),
    .i_dat (word_p0),
    .o_vld (o_str.val),
    .i_rdy (o_str.rdy),
    .o_dat (word_p1)
  );

  assign {o_str.dat, o_str.ctl, o_str.mod, o_str.sop, o_str.eop, o_str.err} = word_p1;

  assign hs = o_str.val && o_str.rdy;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pkt_cnt <= '0;
      o_err_cnt <= '0;
    end else if (hs) begin
      if (o_str.eop) o_pkt_cnt <= o_pkt_cnt + CNT_BITS'(1);
      if (o_str.err && (o_err_cnt != '1)) o_err_cnt <= o_err_cnt + ERR_CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_axis_to_stream_rx.sv
// Self-checking bench for axis_to_stream_rx: scenario tasks drive AXI4-Stream
// beats, a reference model fills a scoreboard, a monitor compares output beats.
module tb_axis_to_stream_rx;

  typedef struct packed {
    logic [511:0] dat;
    logic [7:0]   ctl;
    logic [5:0]   mod;
    logic         sop;
    logic         eop;
    logic         err;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tvalid = 1'b0;
  logic [511:0] tdata = '0;
  logic [63:0]  tkeep = '0;
  logic         tlast = 1'b0;
  logic [7:0]   tuser = '0;
  wire          tready;
  wire  [31:0]  pkt_cnt;
  wire  [15:0]  err_cnt;

  int    checks = 0;
  int    failures = 0;
  int    rdy_mode = 2;
  int    stall_cnt = 0;
  beat_t sb[$];
  logic  m_in_pkt = 1'b0;
  int    m_pkt = 0;
  int    m_err = 0;

  if_axi_stream #(.DAT_BYTS(64), .CTL_BITS(8), .MOD_BITS(6)) str ();

  axis_to_stream_rx #(.DAT_BYTS(64), .CTL_BITS(8), .MOD_BITS(6), .CNT_BITS(32)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_axis_tvalid (tvalid),
    .o_axis_tready (tready),
    .i_axis_tdata  (tdata),
    .i_axis_tkeep  (tkeep),
    .i_axis_tlast  (tlast),
    .i_axis_tuser  (tuser),
    .o_str         (str),
    .o_pkt_cnt     (pkt_cnt),
    .o_err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] rand_dat();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [63:0] low_ones(input int n);
    logic [63:0] k;
    k = '0;
    for (int i = 0; i < n; i++) k[i] = 1'b1;
    return k;
  endfunction

  // Reference model: expected output beat derived bit-by-bit from the input.
  task automatic model_push(input logic [511:0] d, input logic [63:0] k,
                            input logic l, input logic [7:0] u);
    int    cnt;
    logic  seen_zero;
    logic  gap_one;
    beat_t b;
    if (k == '0 && !l) return;
    cnt = 0; seen_zero = 1'b0; gap_one = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (k[i]) begin
        cnt++;
        if (seen_zero) gap_one = 1'b1;
      end else begin
        seen_zero = 1'b1;
      end
    end
    b.dat = d;
    b.ctl = u;
    b.mod = l ? 6'(cnt % 64) : 6'd0;
    b.sop = !m_in_pkt;
    b.eop = l;
    b.err = l ? (gap_one || k == '0) : (k != {64{1'b1}});
    m_in_pkt = !l;
    if (b.eop) m_pkt++;
    if (b.err) m_err++;
    sb.push_back(b);
  endtask

  // Drive one beat and hold it until the DUT accepts it.
  task automatic put(input logic [511:0] d, input logic [63:0] k,
                     input logic l, input logic [7:0] u, input int gap);
    int   waited;
    logic rs;
    tvalid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    model_push(d, k, l, u);
    tvalid = 1'b1; tdata = d; tkeep = k; tlast = l; tuser = u;
    waited = 0;
    forever begin
      @(negedge clk); rs = tready;
      @(posedge clk); #1;
      if (rs) break;
      waited++;
      if (waited > 2000) begin
        failures++;
        $display("FAIL put_timeout got=no_accept want=accept");
        break;
      end
    end
    stall_cnt += waited;
    tvalid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    m_in_pkt = 1'b0; m_pkt = 0; m_err = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (tready !== 1'b0) begin failures++; $display("FAIL rst_tready got=%b want=0", tready); end
    checks++; if (str.val !== 1'b0) begin failures++; $display("FAIL rst_val got=%b want=0", str.val); end
    checks++; if ({str.sop, str.eop, str.err} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b want=000", {str.sop, str.eop, str.err}); end
    checks++; if ({str.mod, str.ctl} !== 14'd0 || str.dat !== '0) begin failures++; $display("FAIL rst_fields got mod=%0d ctl=%0d want=0", str.mod, str.ctl); end
    checks++; if (pkt_cnt !== 32'd0 || err_cnt !== 16'd0) begin failures++; $display("FAIL rst_cnt got=%0d/%0d want=0/0", pkt_cnt, err_cnt); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (tready !== 1'b1) begin failures++; $display("FAIL rst_tready_rise got=%b want=1", tready); end
  endtask

  task automatic test_single_200();
    rdy_mode = 0; stall_cnt = 0;
    @(posedge clk); #1;
    for (int b = 0; b < 3; b++) put(rand_dat(), '1, 1'b0, 8'(b + 1), 0);
    put(rand_dat(), 64'h00FF, 1'b1, 8'h44, 0);
    drain(50);
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL single_drain got=%0d want=0 pending", sb.size()); end
    checks++; if (pkt_cnt !== 32'd1) begin failures++; $display("FAIL single_pkt_cnt got=%0d want=1", pkt_cnt); end
    checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL single_err_cnt got=%0d want=0", err_cnt); end
    checks++; if (stall_cnt != 0) begin failures++; $display("FAIL single_tready got=%0d stalls want=0", stall_cnt); end
  endtask

  task automatic test_back_to_back();
    stall_cnt = 0;
    put(rand_dat(), '1, 1'b1, 8'hA0, 0);
    put(rand_dat(), '1, 1'b0, 8'hA1, 0);
    put(rand_dat(), '1, 1'b1, 8'hA2, 0);
    drain(50);
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL b2b_drain got=%0d want=0 pending", sb.size()); end
    checks++; if (pkt_cnt !== 32'd3) begin failures++; $display("FAIL b2b_pkt_cnt got=%0d want=3", pkt_cnt); end
    checks++; if (stall_cnt != 0) begin failures++; $display("FAIL b2b_tready got=%0d stalls want=0", stall_cnt); end
  endtask

  task automatic test_keep_err();
    put(rand_dat(), 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 8'h10, 0);
    put(rand_dat(), 64'h0F0F, 1'b1, 8'h11, 0);
    put(rand_dat(), 64'h0, 1'b1, 8'h12, 0);
    drain(50);
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL kerr_drain got=%0d want=0 pending", sb.size()); end
    checks++; if (err_cnt !== 16'd3) begin failures++; $display("FAIL kerr_err_cnt got=%0d want=3", err_cnt); end
    checks++; if (pkt_cnt !== 32'd5) begin failures++; $display("FAIL kerr_pkt_cnt got=%0d want=5", pkt_cnt); end
  endtask

  task automatic test_null();
    put(rand_dat(), '1, 1'b0, 8'h20, 0);
    put(rand_dat(), 64'h0, 1'b0, 8'h21, 0);
    put(rand_dat(), 64'h000F, 1'b1, 8'h22, 0);
    drain(50);
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL null_drain got=%0d want=0 pending", sb.size()); end
    checks++; if (pkt_cnt !== 32'd6) begin failures++; $display("FAIL null_pkt_cnt got=%0d want=6", pkt_cnt); end
  endtask

  task automatic test_random();
    int          len;
    logic [63:0] k;
    rdy_mode = 1;
    for (int p = 0; p < 1000; p++) begin
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        if (b != 0 && $urandom_range(0, 29) == 0) put(rand_dat(), 64'h0, 1'b0, 8'($urandom), 0);
        if (b != len - 1) begin
          k = ($urandom_range(0, 49) == 0) ? {$urandom, $urandom} : '1;
        end else if ($urandom_range(0, 9) == 0) begin
          k = {$urandom, $urandom};
        end else begin
          k = low_ones($urandom_range(1, 64));
        end
        put(rand_dat(), k, b == len - 1, 8'($urandom), ($urandom_range(0, 3) == 0) ? 1 : 0);
      end
    end
    drain(20000);
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL rand_drain got=%0d want=0 pending", sb.size()); end
    checks++; if (pkt_cnt !== 32'(m_pkt)) begin failures++; $display("FAIL rand_pkt_cnt got=%0d want=%0d", pkt_cnt, m_pkt); end
    checks++; if (err_cnt !== 16'(m_err)) begin failures++; $display("FAIL rand_err_cnt got=%0d want=%0d", err_cnt, m_err); end
  endtask

  task automatic test_reset_mid();
    rdy_mode = 2;
    @(posedge clk); @(posedge clk); #1;
    put(rand_dat(), '1, 1'b0, 8'h30, 0);
    put(rand_dat(), '1, 1'b0, 8'h31, 0);
    tvalid = 1'b1; tdata = rand_dat(); tkeep = '1; tlast = 1'b0; tuser = 8'h32;
    @(posedge clk); #1;
    checks++; if (tready !== 1'b0 || str.val !== 1'b1) begin failures++; $display("FAIL mid_stall got tready=%b val=%b want=0/1", tready, str.val); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (str.val !== 1'b0 || {str.sop, str.eop, str.err} !== 3'b000) begin failures++; $display("FAIL mid_rst_out got val=%b flags=%b want=0/000", str.val, {str.sop, str.eop, str.err}); end
    checks++; if (str.dat !== '0 || {str.mod, str.ctl} !== 14'd0 || tready !== 1'b0) begin failures++; $display("FAIL mid_rst_fields got ctl=%0d tready=%b want=0/0", str.ctl, tready); end
    checks++; if (pkt_cnt !== 32'd0 || err_cnt !== 16'd0) begin failures++; $display("FAIL mid_rst_cnt got=%0d/%0d want=0/0", pkt_cnt, err_cnt); end
    tvalid = 1'b0;
    sb.delete();
    m_in_pkt = 1'b0; m_pkt = 0; m_err = 0;
    rst = 1'b0;
    rdy_mode = 0;
    put(rand_dat(), 64'h3, 1'b1, 8'h33, 0);
    drain(50);
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL mid_drain got=%0d want=0 pending", sb.size()); end
    checks++; if (pkt_cnt !== 32'd1) begin failures++; $display("FAIL mid_pkt_cnt got=%0d want=1", pkt_cnt); end
  endtask

  initial begin
    str.rdy = 1'b0;
    fork
      forever begin
        @(posedge clk); #1;
        case (rdy_mode)
          0:       str.rdy = 1'b1;
          1:       str.rdy = 1'($urandom_range(0, 1));
          default: str.rdy = 1'b0;
        endcase
      end
      forever begin
        beat_t got;
        beat_t exp;
        @(negedge clk);
        if (!rst && str.val && str.rdy) begin
          got = {str.dat, str.ctl, str.mod, str.sop, str.eop, str.err};
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL beat_unexpected got sop=%b eop=%b ctl=%h want=none", got.sop, got.eop, got.ctl);
          end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
              failures++;
              $display("FAIL beat got sop=%b eop=%b err=%b mod=%0d ctl=%h want sop=%b eop=%b err=%b mod=%0d ctl=%h dat_ok=%b",
                       got.sop, got.eop, got.err, got.mod, got.ctl,
                       exp.sop, exp.eop, exp.err, exp.mod, exp.ctl, got.dat === exp.dat);
            end
          end
        end
      end
      begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
      end
    join_none

    test_reset();
    test_single_200();
    test_back_to_back();
    test_keep_err();
    test_null();
    test_random();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
